img_frame_streamer: RTL and testbench



---
 rtl/cnn_img_pkg.sv | 15 +
 rtl/img_frame_slot.sv | 44 ++++
 rtl/img_frame_streamer.sv | 133 +++++++++++++
 tb/tb_img_frame_streamer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_img_pkg.sv
// Shared image geometry and assembly-state encoding for the CNN front end.
package cnn_img_pkg;

    localparam int unsigned IMG_W      = 12;
    localparam int unsigned IMG_H      = 12;
    localparam int unsigned PIX_W      = 8;
    localparam int unsigned FRAME_BITS = IMG_W * IMG_H * PIX_W;
    localparam int unsigned PCNT_W     = $clog2(IMG_W * IMG_H);

    typedef enum logic {
        FILL  = 1'b0,
        STALL = 1'b1
    } asm_state_e;

endpackage

// File: rtl/img_frame_slot.sv
// One-entry valid/ready register slice holding a complete frame for the consumer.
module img_frame_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         full_q;
    logic         full_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Caller only loads when empty or draining this cycle, so load wins outright.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (load) begin
            full_d = 1'b1;
            data_d = load_data;
        end else if (full_q && out_ready) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign out_valid = full_q;
    assign out_data  = data_q;

endmodule

// File: rtl/img_frame_streamer.sv
// Packs a byte-serial raster pixel stream into full frames, double-buffered
// between an assembly shift register and a one-entry output slot.
module img_frame_streamer #(
    parameter int unsigned IMG_W      = cnn_img_pkg::IMG_W,
    parameter int unsigned IMG_H      = cnn_img_pkg::IMG_H,
    parameter int unsigned PIX_W      = cnn_img_pkg::PIX_W,
    parameter int unsigned FRAME_BITS = IMG_W * IMG_H * PIX_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [PIX_W-1:0]      pix_data,
    input  logic                  pix_last,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  frame_err,
    output logic [31:0]           frame_cnt
);

    import cnn_img_pkg::asm_state_e;
    import cnn_img_pkg::FILL;
    import cnn_img_pkg::STALL;

    localparam int unsigned NPIX   = IMG_W * IMG_H;
    localparam int unsigned PCNT_W = $clog2(NPIX);

    asm_state_e              state_q;
    asm_state_e              state_d;
    logic [PCNT_W-1:0]       pcnt_q;
    logic [PCNT_W-1:0]       pcnt_d;
    logic [FRAME_BITS-1:0]   asm_q;
    logic [FRAME_BITS-1:0]   asm_d;
    logic                    pix_ready_q;
    logic                    pix_ready_d;
    logic                    err_q;
    logic                    err_d;
    logic [31:0]             cnt_q;
    logic [31:0]             cnt_d;

    logic                    pix_xfer;
    logic                    frame_xfer;
    logic                    last_idx;
    logic                    slot_free;
    logic                    slot_load;
    logic [FRAME_BITS-1:0]   slot_load_data;
    logic [FRAME_BITS-1:0]   full_frame;

    assign pix_xfer   = pix_valid && pix_ready_q;
    assign frame_xfer = frame_valid && frame_ready;
    assign last_idx   = (pcnt_q == PCNT_W'(NPIX - 1));
    assign slot_free  = !frame_valid || frame_ready;

    // Shift-in packing: after NPIX pixels, pixel 0 sits in the MSBs.
    assign full_frame = {asm_q[FRAME_BITS-PIX_W-1:0], pix_data};

    // Assembly FSM, pixel counter and framing checks.
    always_comb begin
        state_d        = state_q;
        pcnt_d         = pcnt_q;
        asm_d          = asm_q;
        err_d          = 1'b0;
        slot_load      = 1'b0;
        slot_load_data = full_frame;
        unique case (state_q)
            FILL: begin
                if (pix_xfer) begin
                    asm_d = full_frame;
                    if (last_idx) begin
                        pcnt_d = '0;
                        err_d  = !pix_last;
                        if (slot_free) begin
                            slot_load = 1'b1;
                        end else begin
                            state_d = STALL;
                        end
                    end else if (pix_last) begin
                        pcnt_d = '0;
                        err_d  = 1'b1;
                    end else begin
                        pcnt_d = pcnt_q + PCNT_W'(1);
                    end
                end
            end
            STALL: begin
                if (frame_xfer) begin
                    slot_load      = 1'b1;
                    slot_load_data = asm_q;
                    state_d        = FILL;
                end
            end
            default: state_d = FILL;
        endcase
        pix_ready_d = (state_d == FILL);
        cnt_d       = frame_xfer ? cnt_q + 32'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FILL;
            pcnt_q      <= '0;
            asm_q       <= '0;
            pix_ready_q <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pcnt_q      <= pcnt_d;
            asm_q       <= asm_d;
            pix_ready_q <= pix_ready_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    img_frame_slot #(
        .W (FRAME_BITS)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (slot_load),
        .load_data (slot_load_data),
        .out_valid (frame_valid),
        .out_ready (frame_ready),
        .out_data  (frame_data)
    );

    assign pix_ready = pix_ready_q;
    assign frame_err = err_q;
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_img_frame_streamer.sv
// Self-checking bench: table-driven phases plus random traffic against a
// queue-based frame model.
module tb_img_frame_streamer;

    localparam int NPIX = 144;
    localparam int FB   = 1152;

    logic          clk;
    logic          rst;
    logic          pix_valid;
    logic          pix_ready;
    logic [7:0]    pix_data;
    logic          pix_last;
    logic          frame_valid;
    logic          frame_ready;
    logic [FB-1:0] frame_data;
    logic          frame_err;
    logic [31:0]   frame_cnt;

    img_frame_streamer dut (
        .clk         (clk),
        .rst         (rst),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_last    (pix_last),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .frame_err   (frame_err),
        .frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pixels of the frame in progress, completed-but-undelivered frames.
    logic [7:0]    part[$];
    logic [FB-1:0] expq[$];
    logic [31:0]   cnt_exp;
    bit            err_exp;
    bit            ready_ok;
    int            err_seen;
    logic [7:0]    pval;

    int n_cmp;
    int n_fail;

    typedef struct {
        int npix;
        int mode;      // 0: never last, 1: last on every 144th pixel, 2: last at lidx
        int lidx;
        bit fr;
        int exp_cnt;
        int exp_err;
    } row_t;

    row_t rows[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_frame(input string name, input logic [FB-1:0] exp);
        n_cmp++;
        if (frame_data !== exp) begin
            n_fail++;
            $display("FAIL %s: got low64 %h msb %h expected low64 %h msb %h at %0t",
                     name, frame_data[63:0], frame_data[FB-1:FB-8], exp[63:0], exp[FB-1:FB-8], $time);
        end
    endtask

    function automatic logic [FB-1:0] pack_frame();
        logic [FB-1:0] f;
        f = '0;
        for (int i = 0; i < NPIX; i++) f[FB-1-i*8 -: 8] = part[i];
        return f;
    endfunction

    // Check outputs at the negedge, drive inputs, advance the model, step one clock.
    task automatic cycle(input bit pv, input logic [7:0] pd, input bit pl, input bit fr, output bit took);
        bit fx;
        chk("frame_valid", 64'(frame_valid), 64'(expq.size() != 0));
        chk("pix_ready", 64'(pix_ready), 64'(ready_ok && expq.size() < 2));
        chk("frame_err", 64'(frame_err), 64'(err_exp));
        chk("frame_cnt", 64'(frame_cnt), 64'(cnt_exp));
        if (expq.size() != 0) chk_frame("frame_data", expq[0]);
        if (frame_err) err_seen++;

        pix_valid   = pv;
        pix_data    = pd;
        pix_last    = pl;
        frame_ready = fr;

        took    = pv && ready_ok && (expq.size() < 2);
        fx      = fr && (expq.size() != 0);
        err_exp = 1'b0;
        if (fx) begin
            void'(expq.pop_front());
            cnt_exp++;
        end
        if (took) begin
            part.push_back(pd);
            if (part.size() == NPIX) begin
                expq.push_back(pack_frame());
                err_exp = !pl;
                part.delete();
            end else if (pl) begin
                err_exp = 1'b1;
                part.delete();
            end
        end
        @(posedge clk);
        ready_ok = 1'b1;
        @(negedge clk);
    endtask

    task automatic stream(input int npix, input int mode, input int lidx, input bit fr);
        int i;
        int guard;
        bit took;
        bit pl;
        i = 0;
        guard = 0;
        while (i < npix) begin
            pl = (mode == 1) ? ((i % NPIX) == NPIX - 1) : (mode == 2) ? (i == lidx) : 1'b0;
            cycle(1'b1, pval, pl, fr, took);
            if (took) begin
                pval++;
                i++;
            end
            guard++;
            if (guard > 5000) begin
                n_cmp++;
                n_fail++;
                $display("FAIL stream_timeout: accepted %0d of %0d pixels", i, npix);
                return;
            end
        end
    endtask

    task automatic idle(input int n, input bit fr);
        bit took;
        for (int k = 0; k < n; k++) cycle(1'b0, 8'h00, 1'b0, fr, took);
    endtask

    task automatic clear_model();
        part.delete();
        expq.delete();
        cnt_exp  = '0;
        err_exp  = 1'b0;
        ready_ok = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_fv"}, 64'(frame_valid), 64'(0));
        chk({tag, "_pr"}, 64'(pix_ready), 64'(0));
        chk({tag, "_err"}, 64'(frame_err), 64'(0));
        chk({tag, "_cnt"}, 64'(frame_cnt), 64'(0));
        chk_frame({tag, "_data"}, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit took;
        bit pv;
        bit fr;
        bit pl;

        n_cmp = 0;
        n_fail = 0;
        err_seen = 0;
        pval = 8'h00;
        clear_model();

        rows[0] = '{npix: 144, mode: 1, lidx: 0,  fr: 1'b1, exp_cnt: 1, exp_err: 0};
        rows[1] = '{npix: 144, mode: 1, lidx: 0,  fr: 1'b0, exp_cnt: 1, exp_err: 0};
        rows[2] = '{npix: 144, mode: 1, lidx: 0,  fr: 1'b0, exp_cnt: 1, exp_err: 0};
        rows[3] = '{npix: 0,   mode: 0, lidx: 0,  fr: 1'b1, exp_cnt: 3, exp_err: 0};
        rows[4] = '{npix: 51,  mode: 2, lidx: 50, fr: 1'b1, exp_cnt: 3, exp_err: 1};
        rows[5] = '{npix: 144, mode: 1, lidx: 0,  fr: 1'b1, exp_cnt: 4, exp_err: 1};
        rows[6] = '{npix: 144, mode: 0, lidx: 0,  fr: 1'b1, exp_cnt: 5, exp_err: 2};
        rows[7] = '{npix: 432, mode: 1, lidx: 0,  fr: 1'b1, exp_cnt: 8, exp_err: 2};

        rst = 1'b0;
        pix_valid = 1'b0;
        pix_data = 8'h00;
        pix_last = 1'b0;
        frame_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        for (int r = 0; r < 8; r++) begin
            stream(rows[r].npix, rows[r].mode, rows[r].lidx, rows[r].fr);
            idle(3, rows[r].fr);
            chk($sformatf("row%0d_cnt", r), 64'(frame_cnt), 64'(rows[r].exp_cnt));
            chk($sformatf("row%0d_errs", r), 64'(err_seen), 64'(rows[r].exp_err));
            if (r == 0) begin
                chk("row0_fv_idle", 64'(frame_valid), 64'(0));
            end
            if (r == 2) begin
                // Frame carried pixels 144..287; both buffers full.
                chk("stall_pix_ready", 64'(pix_ready), 64'(0));
                chk("held_msb", 64'(frame_data[FB-1:FB-8]), 64'(8'h90));
                chk("held_lsb", 64'(frame_data[7:0]), 64'(8'h1F));
            end
        end

        // Randomized traffic with occasional framing errors.
        for (int c = 0; c < 3000; c++) begin
            pv = ($urandom_range(9) < 7);
            fr = ($urandom_range(9) < 6);
            if (part.size() == NPIX - 1) pl = ($urandom_range(19) != 0);
            else                         pl = ($urandom_range(299) == 0);
            cycle(pv, pval, pl, fr, took);
            if (took) pval++;
        end
        idle(4, 1'b1);

        // Mid-frame asynchronous reset, then a clean frame.
        stream(70, 0, 0, 1'b1);
        pix_valid = 1'b0;
        frame_ready = 1'b0;
        #2 rst = 1'b0;
        #1 check_reset_outputs("midrst");
        clear_model();
        err_seen = 0;
        @(negedge clk);
        rst = 1'b1;
        pval = 8'hA0;
        stream(144, 1, 0, 1'b1);
        idle(3, 1'b1);
        chk("post_rst_cnt", 64'(frame_cnt), 64'(1));
        chk("post_rst_errs", 64'(err_seen), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
